// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB requester types and default widths
package apb_pkg;

   localparam int APB_ADDR_W = 32;
   localparam int APB_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SETUP  = 2'b01,
      ACCESS = 2'b10,
      RESP   = 2'b11
   } apb_state_e;

endpackage

// File: rtl/apb_timeout_ctr.sv
// rtl/apb_timeout_ctr.sv - counts consecutive stalled ACCESS cycles
// expired marks the LIMIT-th consecutive counted cycle, so the caller aborts on that edge.
module apb_timeout_ctr #(
   parameter int LIMIT = 16
) (
   input  logic PCLK,
   input  logic PRESETn,
   input  logic clear,
   input  logic count,
   output logic expired
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (count && !expired) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign expired = count && (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/apb_master_ctrl.sv
// rtl/apb_master_ctrl.sv - single-outstanding APB requester with command/response handshakes
// Optional ACCESS timeout is compiled in with APB_MASTER_TIMEOUT_EN.
module apb_master_ctrl
   import apb_pkg::*;
#(
   parameter int ADDR_W      = APB_ADDR_W,
   parameter int DATA_W      = APB_DATA_W,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] PADDR,
   output logic              PWRITE,
   output logic              PSEL,
   output logic              PENABLE,
   output logic [DATA_W-1:0] PWDATA,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PREADY,
   input  logic              PSLVERR
);

   apb_state_e state, state_nxt;
   logic       tmo_expired;
   logic       cmd_hs;

   assign cmd_hs = (state == IDLE) && cmd_valid && cmd_ready;

`ifdef APB_MASTER_TIMEOUT_EN
   apb_timeout_ctr #(
      .LIMIT (TIMEOUT_CYC)
   ) u_timeout_ctr (
      .PCLK    (PCLK),
      .PRESETn (PRESETn),
      .clear   (state == SETUP),
      .count   ((state == ACCESS) && !PREADY),
      .expired (tmo_expired)
   );
`else
   // ACCESS waits indefinitely; the parameter only keeps the interface uniform.
   assign tmo_expired = 1'b0 && (TIMEOUT_CYC > 0);
`endif

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (cmd_hs) state_nxt = SETUP;
         SETUP:   state_nxt = ACCESS;
         ACCESS:  if (PREADY || tmo_expired) state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Every output is a flop loaded from the next-state decode, so none sees an input combinationally.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         cmd_ready <= 1'b0;
         PSEL      <= 1'b0;
         PENABLE   <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         PADDR     <= '0;
         PWRITE    <= 1'b0;
         PWDATA    <= '0;
      end else begin
         cmd_ready <= (state_nxt == IDLE);
         PSEL      <= (state_nxt == SETUP) || (state_nxt == ACCESS);
         PENABLE   <= (state_nxt == ACCESS);
         rsp_valid <= (state_nxt == RESP);
         if (cmd_hs) begin
            PADDR  <= cmd_addr;
            PWRITE <= cmd_write;
            PWDATA <= cmd_wdata;
         end
         if (state == ACCESS) begin
            if (PREADY) begin
               rsp_err   <= PSLVERR;
               rsp_rdata <= PWRITE ? '0 : PRDATA;
            end else if (tmo_expired) begin
               rsp_err   <= 1'b1;
               rsp_rdata <= '0;
            end
         end
      end
   end

endmodule

// File: doc/apb_master_ctrl.md
APB_MASTER_CTRL -- requirements
Module: apb_master_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32: width of the command address and PADDR.
REQ-002 The block SHALL have parameter DATA_W, default 32: width of all data paths.
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 16: number of ACCESS cycles allowed before abort; used only when timeout is compiled in.
REQ-004 PCLK  in  1  clock; all logic is on the rising edge.
REQ-005 PRESETn  in  1  reset, asynchronous, active-low.
REQ-006 cmd_valid  in  1  request present.
REQ-007 cmd_ready  out  1  request accepted this cycle.
REQ-008 cmd_write  in  1  request type: 1 = write, 0 = read.
REQ-009 cmd_addr  in  ADDR_W  target address.
REQ-010 cmd_wdata  in  DATA_W  write data.
REQ-011 rsp_valid  out  1  response present.
REQ-012 rsp_ready  in  1  response consumed.
REQ-013 rsp_rdata  out  DATA_W  read data; 0 for writes.
REQ-014 rsp_err  out  1  slave error or timeout.
REQ-015 PADDR, PWRITE, PSEL, PENABLE, PWDATA  out  ADDR_W/1/1/1/DATA_W  APB requester outputs.
REQ-016 PRDATA, PREADY, PSLVERR  in  DATA_W/1/1  APB completer inputs.

Function
REQ-017 The FSM SHALL have four states: IDLE, SETUP, ACCESS and RESP.
REQ-018 cmd_ready SHALL be 1 only in IDLE. A handshake (cmd_valid & cmd_ready) SHALL latch cmd_write, cmd_addr and cmd_wdata into PWRITE, PADDR and PWDATA, then go to SETUP.
REQ-019 In SETUP, PSEL SHALL be 1 and PENABLE 0, for exactly one cycle, then the FSM goes to ACCESS.
REQ-020 In ACCESS, PSEL and PENABLE SHALL both be 1. PADDR, PWRITE and PWDATA SHALL stay stable until the transfer completes.
REQ-021 In ACCESS with PREADY=1, the block SHALL:
- capture rsp_err = PSLVERR;
- capture rsp_rdata = PRDATA for reads and 0 for writes;
- drop PSEL and PENABLE on the next edge;
- go to RESP.
REQ-022 In ACCESS with PREADY=0, the block SHALL stay in ACCESS (wait states, unbounded unless REQ-031 applies).
REQ-023 In RESP, rsp_valid SHALL be 1, with rsp_rdata and rsp_err held stable, until rsp_ready=1. The FSM then returns to IDLE.
REQ-024 Only one transfer SHALL be outstanding. Minimum latency from the command handshake edge to rsp_valid=1 SHALL be 3 cycles (zero wait states). Minimum command-to-command spacing SHALL be 4 cycles.
REQ-025 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-026 PSEL=1 with PENABLE=1 SHALL never directly follow IDLE. PENABLE SHALL never be 1 while PSEL=0.

Reset
REQ-027 Asserting PRESETn SHALL immediately force the FSM to IDLE and clear all outputs to 0, except cmd_ready, which SHALL be 0 during reset and 1 on the first cycle after release.
REQ-028 Reset mid-transfer (SETUP, ACCESS or RESP) SHALL abandon the transfer with no response. PSEL and PENABLE SHALL drop asynchronously.

Configuration
REQ-029 Macro APB_MASTER_TIMEOUT_EN SHALL control the timeout feature.
REQ-030 Without the macro, ACCESS SHALL wait indefinitely for PREADY, and no counter logic SHALL be present.
REQ-031 With the macro, the block SHALL:
- count consecutive ACCESS cycles with PREADY=0;
- abort when the count reaches TIMEOUT_CYC: drop PSEL and PENABLE, go to RESP with rsp_err=1 and rsp_rdata=0;
- give PREADY=1 priority on the cycle the limit is reached;
- clear the counter on every entry to ACCESS.

Structure
REQ-032 Shared package apb_pkg SHALL hold the FSM state enum (IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10, RESP=2'b11) and the default ADDR_W and DATA_W constants.
REQ-033 The timeout counter SHALL be sub-module apb_timeout_ctr (inputs clear and count, output expired), instantiated only under APB_MASTER_TIMEOUT_EN.

Verification
REQ-034 Write to addr 0x10 with data 0xDEADBEEF, PREADY tied to 1. Required: PSEL=1 for 2 cycles, PENABLE=1 on the second only, PADDR=0x10 and PWDATA=0xDEADBEEF stable; rsp_valid 3 cycles after the handshake with rsp_rdata=0 and rsp_err=0.
REQ-035 Read from addr 0x08, PREADY low for 3 ACCESS cycles, then PRDATA=0x12345678 with PREADY=1. Required: ACCESS lasts 4 cycles; rsp_rdata=0x12345678.
REQ-036 Read with PSLVERR=1 at completion. Required: rsp_err=1; rsp_valid held for 5 cycles while rsp_ready=0; cmd_ready=0 throughout.
REQ-037 With APB_MASTER_TIMEOUT_EN and TIMEOUT_CYC=4, PREADY held at 0. Required: PSEL drops after 4 ACCESS cycles; rsp_err=1 and rsp_rdata=0. Without the macro: still in ACCESS after 100 cycles.
REQ-038 PRESETn asserted during ACCESS. Required: PSEL, PENABLE and rsp_valid are 0 immediately; after release, cmd_ready=1 and a new write to 0x20 completes normally.
